// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, parameter
// defaults and small width helpers used by the FSM and its testbench.
package pll_ctrl_pkg;

    // Sequencer states, in the order a clean power-up walks through them.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Default timing: 50 MHz reference clock.
    localparam int DEF_PLL_RST_CYCLES = 16;     // PLL reset pulse per attempt
    localparam int DEF_LOCK_TIMEOUT   = 50000;  // 1 ms lock window per attempt
    localparam int DEF_LOCK_STABLE    = 1024;   // consecutive locked cycles before release
    localparam int DEF_MAX_RETRIES    = 3;      // failed attempts before FAULT

    // Largest of three values, used to size the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit width needed to hold 0..v-1, never narrower than one bit.
    function automatic int width_for(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Both flops clear on reset so the synchronised level starts deasserted.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock with a timeout and
// a bounded number of retries, demands a stable lock window before releasing
// the system reset, and re-acquires whenever lock is lost while running.
// All outputs are registered and decoded from the state being entered, so
// they switch on the same edge as the state transition.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       timeout_err,
    output logic [7:0] lock_lost_count
);

    // One counter serves all timed states, so it only needs to reach the
    // longest of the three intervals.
    localparam int CNT_W   = width_for(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));
    localparam int RETRY_W = width_for(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    pll_state_e         state;
    pll_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lost_inc;
    logic               rst_pend;
    logic               locked_s;

    // Saturating increment for the lock-loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // pll_locked comes from the PLL's own clock domain; nothing below sees it raw.
    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state decision. A software request always wins over the state's
    // own progress, except that a lock loss in RUN is still counted.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        retry_nxt = retry_cnt;
        lost_inc  = 1'b0;

        case (state)
            RESET_PLL: begin
                // The edge right after reset release only opens the window
                // (rst_pend), so the PLL always gets the full reset pulse.
                if (sw_reset_req) begin
                    cnt_clr = 1'b1;
                end else if (!rst_pend && cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                if (sw_reset_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + RETRY_W'(1);
                    state_nxt = (retry_cnt == RETRY_LAST) ? FAULT : RESET_PLL;
                end
            end

            STABLE: begin
                // A single dropout restarts the lock wait with a fresh timeout,
                // without charging a retry.
                if (sw_reset_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end

            RUN: begin
                lost_inc = !locked_s;
                if (sw_reset_req || !locked_s) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end

            FAULT: begin
                if (sw_reset_req) begin
                    state_nxt = RESET_PLL;
                    retry_nxt = '0;
                end
            end

            default: begin
                state_nxt = RESET_PLL;
                retry_nxt = '0;
            end
        endcase

        if (state_nxt != state) begin
            cnt_clr = 1'b1;
        end
    end

    // State, counters and outputs; outputs are decoded from state_nxt so
    // they line up with the transition edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            retry_cnt       <= '0;
            rst_pend        <= 1'b1;
            pll_rst         <= 1'b1;
            sys_rst_n       <= 1'b0;
            ready           <= 1'b0;
            timeout_err     <= 1'b0;
            lock_lost_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            rst_pend  <= 1'b0;

            if (cnt_clr || rst_pend) begin
                cnt <= '0;
            end else if (state inside {RESET_PLL, WAIT_LOCK, STABLE}) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (lost_inc) begin
                lock_lost_count <= sat_inc8(lock_lost_count);
            end

            pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
            sys_rst_n   <= (state_nxt == RUN);
            ready       <= (state_nxt == RUN);
            timeout_err <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer with small timing parameters. A behavioural
// model (countdown timers, a two-deep history queue for the synchroniser)
// predicts every output each cycle; directed sequences add explicit checks.
module tb_pll_lock_sequencer;

    localparam int PRC = 4;
    localparam int LT  = 100;
    localparam int LS  = 8;
    localparam int MR  = 2;

    localparam int M_RST   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       timeout_err;
    logic [7:0] lock_lost_count;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int   m_phase;
    int   m_left;
    int   m_tries;
    int   m_lost;
    logic m_hist[$];

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .LOCK_STABLE    (LS),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .sw_reset_req    (sw_reset_req),
        .pll_rst         (pll_rst),
        .sys_rst_n       (sys_rst_n),
        .ready           (ready),
        .timeout_err     (timeout_err),
        .lock_lost_count (lock_lost_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {pll_rst, sys_rst_n, ready, timeout_err, lock_lost_count};
    endfunction

    function automatic logic [11:0] m_out();
        logic in_rst, in_run, in_fault;
        in_rst   = (m_phase == M_RST);
        in_run   = (m_phase == M_RUN);
        in_fault = (m_phase == M_FAULT);
        return {in_rst | in_fault, in_run, in_run, in_fault, 8'(m_lost)};
    endfunction

    function automatic void model_reset();
        m_phase = M_RST;
        m_left  = PRC + 1;   // first edge after release opens the reset window
        m_tries = 0;
        m_lost  = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endfunction

    function automatic void enter_rst();
        m_phase = M_RST;
        m_left  = PRC;
    endfunction

    // One refclk edge: lk/sw are the input values sampled at that edge.
    function automatic void model_step(input logic lk, input logic sw);
        logic ls;
        ls = m_hist.pop_front();   // what the FSM sees is pll_locked two edges ago
        m_hist.push_back(lk);
        case (m_phase)
            M_RST: begin
                if (sw) m_left = PRC;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = M_WAIT; m_left = LT; end
                end
            end
            M_WAIT: begin
                if (sw) begin enter_rst(); m_tries = 0; end
                else if (ls) begin m_phase = M_STAB; m_left = LS; end
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_tries++;
                        if (m_tries == MR) m_phase = M_FAULT;
                        else enter_rst();
                    end
                end
            end
            M_STAB: begin
                if (sw) begin enter_rst(); m_tries = 0; end
                else if (!ls) begin m_phase = M_WAIT; m_left = LT; end
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = M_RUN; m_tries = 0; end
                end
            end
            M_RUN: begin
                if (!ls && m_lost < 255) m_lost++;
                if (sw || !ls) begin enter_rst(); m_tries = 0; end
            end
            default: begin
                if (sw) begin enter_rst(); m_tries = 0; end
            end
        endcase
    endfunction

    task automatic cyc(input logic lk, input logic sw);
        pll_locked   = lk;
        sw_reset_req = sw;
        @(posedge refclk);
        model_step(lk, sw);
        #1;
        sw_reset_req = 1'b0;
        check("step", dut_out(), m_out());
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #2;
        check(tag, dut_out(), 12'h800);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        check(tag, ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi;
        int   fe;
        logic lk;

        rst_n        = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        #1;

        // Clean acquisition, lock arriving 10 cycles after release
        do_reset("reset_state");
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b0);
            if (i <= PRC) check("pll_rst_hold", pll_rst, 1);
            if (i == PRC + 1) check("pll_rst_drop", pll_rst, 0);
        end
        for (int i = 1; i <= 11; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 10) check("latency_early", sys_rst_n, 0);
            if (i == 11) begin
                check("latency_sys_rst_n", sys_rst_n, 1);
                check("latency_ready", ready, 1);
            end
        end

        // Never locks: two timed attempts, then FAULT until software request
        do_reset("reset_before_timeout");
        hi = 0;
        fe = 0;
        for (int i = 1; i <= 2 * PRC + 2 * LT + 5; i++) begin
            cyc(1'b0, 1'b0);
            if (fe == 0 && pll_rst && !timeout_err) hi++;
            if (fe == 0 && timeout_err) fe = i;
        end
        check("retry_pll_rst_cycles", hi, 2 * PRC);
        check("fault_entry_edge", fe, 2 * PRC + 2 * LT + 1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        check("fault_hold", {pll_rst, timeout_err}, 2'b11);
        cyc(1'b0, 1'b1);
        check("fault_exit", {pll_rst, timeout_err, sys_rst_n}, 3'b100);

        // One-cycle dropout during the stable window
        do_reset("reset_before_glitch");
        fe = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(i != 10, 1'b0);
            if (fe == 0 && sys_rst_n) fe = i;
        end
        // dropout sampled at edge 10, relock sampled at 11, release 2+1+8 edges on
        check("glitch_release_edge", fe, 21);

        // Lock losses in RUN
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            check("loss_still_running", sys_rst_n, 1);
            cyc(1'b1, 1'b0);
            check("loss_sys_rst_low", sys_rst_n, 0);
            check("loss_count", lock_lost_count, k);
            wait_ready("relock", 40);
        end
        check("lost_three", lock_lost_count, 3);
        for (int k = 4; k <= 300; k++) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
            wait_ready("relock_sat", 40);
        end
        check("lost_saturated", lock_lost_count, 255);

        // Lock loss and software request seen in the same RUN cycle
        do_reset("reset_before_combo");
        wait_ready("combo_run", 40);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("combo_count", lock_lost_count, 1);
        check("combo_pll_rst", {pll_rst, sys_rst_n}, 2'b10);
        cyc(1'b1, 1'b0);
        check("combo_single_entry", {pll_rst, lock_lost_count}, {1'b1, 8'd1});
        wait_ready("combo_relock", 40);

        // Asynchronous reset while in STABLE
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        check("in_stable_lost", lock_lost_count, 2);
        do_reset("async_reset_in_stable");

        // Randomised traffic against the model
        lk = 1'b0;
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 999) < (lk ? 15 : 7)) lk = ~lk;
            if ($urandom_range(0, 999) < 2) do_reset("rand_reset");
            cyc(($urandom_range(0, 99) < 3) ? ~lk : lk, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles the PLL reset is held per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, cycles allowed for lock per attempt (1 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024, consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, failed attempts before FAULT.
REQ-005 SHALL have port refclk  input  1  single clock, 50 MHz PLL reference clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port pll_locked  input  1  PLL locked, asynchronous to refclk.
REQ-008 SHALL have port sw_reset_req  input  1  synchronous single-cycle request to re-lock.
REQ-009 SHALL have port pll_rst  output  1  active-high reset to PLL.
REQ-010 SHALL have port sys_rst_n  output  1  active-low system reset, released only in RUN.
REQ-011 SHALL have port ready  output  1  high exactly while in RUN.
REQ-012 SHALL have port timeout_err  output  1  high exactly while in FAULT.
REQ-013 SHALL have port lock_lost_count  output  8  saturating count of lock losses in RUN.

Function
REQ-014 SHALL synchronise pll_locked through two refclk flops (locked_s); no logic SHALL use raw pll_locked.
REQ-015 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT with one shared cycle counter, cleared on every state change.
REQ-016 RESET_PLL: pll_rst=1, sys_rst_n=0; SHALL go to WAIT_LOCK after exactly PLL_RST_CYCLES cycles.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 SHALL go to STABLE; counter reaching LOCK_TIMEOUT-1 with locked_s=0 SHALL increment retry count and go to RESET_PLL, or to FAULT if the incremented count equals MAX_RETRIES.
REQ-018 STABLE: SHALL go to RUN after LOCK_STABLE consecutive cycles with locked_s=1; any locked_s=0 SHALL return to WAIT_LOCK with a fresh timeout.
REQ-019 RUN: sys_rst_n=1, ready=1, retry count cleared on entry; locked_s=0 SHALL increment lock_lost_count (saturate at 255) and go to RESET_PLL.
REQ-020 sw_reset_req in WAIT_LOCK, STABLE, RUN or FAULT SHALL go to RESET_PLL and clear retry count; in RESET_PLL it SHALL restart the PLL_RST_CYCLES count.
REQ-021 Loss of lock and sw_reset_req in the same RUN cycle SHALL both take effect: count increments, next state RESET_PLL.
REQ-022 FAULT: pll_rst=1, sys_rst_n=0; state SHALL hold until sw_reset_req or rst_n.
REQ-023 All outputs SHALL be registered and decoded from the state being entered, so they change on the transition edge.
REQ-024 Latency: from the first refclk edge sampling pll_locked=1 in WAIT_LOCK, sys_rst_n SHALL rise after exactly 2+1+LOCK_STABLE edges if lock holds.
REQ-025 Counter width SHALL be $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE; retry width $clog2(MAX_RETRIES+1).

Reset
REQ-026 rst_n low SHALL asynchronously force state RESET_PLL, counters 0, sync flops 0, pll_rst=1, sys_rst_n=0, ready=0, timeout_err=0, lock_lost_count=0.
REQ-027 rst_n deassertion SHALL begin a full RESET_PLL period on the first refclk edge; rst_n mid-sequence SHALL abandon all progress.

Structure
REQ-028 State enum and parameter defaults SHALL live in shared package pll_ctrl_pkg.
REQ-029 The two-flop synchroniser SHALL be sub-module sync_2ff; the rest is one FSM module.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-030 Release rst_n, pll_locked rises 10 cycles later -> pll_rst high 4 cycles, sys_rst_n/ready rise exactly 11 edges after pll_locked sampled high.
REQ-031 pll_locked never rises -> two 100-cycle WAIT_LOCK windows, each preceded by 4 cycles pll_rst=1, then timeout_err=1, pll_rst=1 held; sw_reset_req -> timeout_err=0, new RESET_PLL.
REQ-032 pll_locked glitches low 1 cycle at STABLE count 5 -> return to WAIT_LOCK, sys_rst_n stays 0, release 8 cycles after relock.
REQ-033 In RUN, pll_locked low 3 times -> lock_lost_count=3, sys_rst_n low 1 edge after locked_s falls, full reacquire each time; 300 losses -> count 255.
REQ-034 In RUN, pll_locked falls and sw_reset_req pulses same cycle -> count +1, one RESET_PLL entry; rst_n pulse in STABLE -> all outputs at reset values immediately.
